// File: rtl/ifid_pkg.sv
// Shared constants and types for the IF/ID fetch controller: opcodes,
// immediate-select codes, FSM states and the IF/ID register payload.
package ifid_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned OPC_W     = 7;
    localparam int unsigned IMM_SEL_W = 3;
    localparam int unsigned REG_W     = 5;

    localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
    localparam logic [OPC_W-1:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
    localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
    localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
    localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
    localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
    localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;

    localparam logic [IMM_SEL_W-1:0] IMM_SEL_U = 3'b000;
    localparam logic [IMM_SEL_W-1:0] IMM_SEL_I = 3'b001;
    localparam logic [IMM_SEL_W-1:0] IMM_SEL_S = 3'b010;
    localparam logic [IMM_SEL_W-1:0] IMM_SEL_B = 3'b011;
    localparam logic [IMM_SEL_W-1:0] IMM_SEL_J = 3'b100;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        HAZ   = 2'd1,
        IWAIT = 2'd2
    } state_t;

    typedef struct packed {
        logic [XLEN-1:0]      inst;
        logic [XLEN-1:0]      pc;
        logic                 valid;
        logic [IMM_SEL_W-1:0] imm_sel;
    } ifid_t;

endpackage

// File: rtl/ifid_imm_sel_dec.sv
// Opcode decode: immediate-select code and which source registers are read.
module ifid_imm_sel_dec
    import ifid_pkg::*;
(
    input  logic [OPC_W-1:0]     opcode,
    output logic [IMM_SEL_W-1:0] imm_sel,
    output logic                 uses_rs1,
    output logic                 uses_rs2
);

    always_comb begin
        imm_sel  = IMM_SEL_U;
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b0;
        case (opcode)
            OPC_LOAD, OPC_OPIMM, OPC_JALR: imm_sel = IMM_SEL_I;
            OPC_STORE: begin
                imm_sel  = IMM_SEL_S;
                uses_rs2 = 1'b1;
            end
            OPC_BRANCH: begin
                imm_sel  = IMM_SEL_B;
                uses_rs2 = 1'b1;
            end
            OPC_JAL: begin
                imm_sel  = IMM_SEL_J;
                uses_rs1 = 1'b0;
            end
            OPC_LUI, OPC_AUIPC: uses_rs1 = 1'b0;
            OPC_OP:             uses_rs2 = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/ifid_fetch_ctrl.sv
// Fetch / IF-ID sequencing: PC, imem fetch, IF/ID register, load-use stall,
// EX redirect and imem wait. Define IFID_EARLY_JAL_EN to redirect jal from ID.
module ifid_fetch_ctrl
    import ifid_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter logic [XLEN-1:0] NOP_INST = 32'h0000_0013
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic [XLEN-1:0]      imem_addr,
    input  logic [XLEN-1:0]      imem_rdata,
    input  logic                 imem_valid,
    input  logic                 ex_redirect,
    input  logic [XLEN-1:0]      ex_target,
    input  logic                 ex_mem_read,
    input  logic [REG_W-1:0]     ex_rd,
    input  logic [XLEN-1:0]      imm_in,
    output logic [XLEN-1:0]      id_inst,
    output logic [XLEN-1:0]      id_pc,
    output logic                 id_valid,
    output logic [IMM_SEL_W-1:0] imm_sel,
    output logic                 hazard_bubble
);

    localparam ifid_t BUBBLE = '{inst: NOP_INST, pc: '0, valid: 1'b0, imm_sel: IMM_SEL_I};

    logic [XLEN-1:0]      pc;
    ifid_t                ifid_q;
    state_t               state;
    logic [IMM_SEL_W-1:0] fetch_sel;
    logic                 fetch_rs1_unused;
    logic                 fetch_rs2_unused;
    logic [IMM_SEL_W-1:0] id_sel_unused;
    logic                 id_uses_rs1;
    logic                 id_uses_rs2;
    logic                 haz;

    // Decode the word arriving from imem so imm_sel lines up with id_inst
    ifid_imm_sel_dec u_fetch_dec (
        .opcode   (imem_rdata[OPC_W-1:0]),
        .imm_sel  (fetch_sel),
        .uses_rs1 (fetch_rs1_unused),
        .uses_rs2 (fetch_rs2_unused)
    );

    // Decode the held instruction for load-use operand checks
    ifid_imm_sel_dec u_id_dec (
        .opcode   (ifid_q.inst[OPC_W-1:0]),
        .imm_sel  (id_sel_unused),
        .uses_rs1 (id_uses_rs1),
        .uses_rs2 (id_uses_rs2)
    );

    always_comb begin
        haz = ifid_q.valid & ex_mem_read & (ex_rd != REG_W'(0)) &
              ((id_uses_rs1 & (ex_rd == ifid_q.inst[19:15])) |
               (id_uses_rs2 & (ex_rd == ifid_q.inst[24:20])));
    end

    assign hazard_bubble = haz & ~ex_redirect;

`ifdef IFID_EARLY_JAL_EN
    logic early_jal;
    assign early_jal = ifid_q.valid & (ifid_q.inst[OPC_W-1:0] == OPC_JAL);

    logic unused_sig;
    assign unused_sig = ^{ex_target[1:0], fetch_rs1_unused, fetch_rs2_unused,
                          id_sel_unused, state};
`else
    logic unused_sig;
    assign unused_sig = ^{imm_in, ex_target[1:0], fetch_rs1_unused, fetch_rs2_unused,
                          id_sel_unused, state};
`endif

    // Priority: reset, EX redirect, load-use hold, early jal, imem wait, advance
    always_ff @(posedge clk) begin
        if (rst) begin
            pc     <= RESET_PC;
            ifid_q <= BUBBLE;
            state  <= RUN;
        end else if (ex_redirect) begin
            pc     <= {ex_target[XLEN-1:2], 2'b00};
            ifid_q <= BUBBLE;
            state  <= RUN;
        end else if (haz) begin
            state  <= HAZ;
`ifdef IFID_EARLY_JAL_EN
        end else if (early_jal) begin
            pc     <= ifid_q.pc + imm_in;
            ifid_q <= BUBBLE;
            state  <= RUN;
`endif
        end else if (!imem_valid) begin
            ifid_q <= BUBBLE;
            state  <= IWAIT;
        end else begin
            ifid_q <= '{inst: imem_rdata, pc: pc, valid: 1'b1, imm_sel: fetch_sel};
            pc     <= pc + XLEN'(4);
            state  <= RUN;
        end
    end

    assign imem_addr = pc;
    assign id_inst   = ifid_q.inst;
    assign id_pc     = ifid_q.pc;
    assign id_valid  = ifid_q.valid;
    assign imm_sel   = ifid_q.imm_sel;

endmodule
